// File: rtl/monolith_chunk_arbiter.sv
// ---------------------------------------------------------------------------
// monolith_chunk_arbiter
// Round-robin scheduler sharing the chunked output FIFO of the Monolith
// AXI-Stream master between N_REQ hash-core producers. One whole chunk is
// captured per handshake into a holding register, then written to the stream
// master with fifo_write_strobe, stalling while fifo_full is high.
//
// Ports:
//   M_AXIS_ACLK        sole clock, rising edge
//   M_AXIS_ARESETN     asynchronous active-low reset
//   enable             1 = new grants allowed
//   req_valid          per-producer chunk offer
//   req_ready          one-hot grant (combinational)
//   req_data           flattened chunks, producer i word w at
//                      (i*FIFO_CHUNK_SIZE+w)*C_M_AXIS_TDATA_WIDTH
//   fifo_write_strobe  write held chunk into stream master (combinational)
//   fifo_in            held chunk, unpacked word array
//   fifo_full          stream master full flag
//   grant_id           index of the producer whose chunk is held
//   busy               holding register valid
//   chunk_count        chunks written, wraps
// ---------------------------------------------------------------------------
module monolith_chunk_arbiter #(
  parameter int unsigned N_REQ                = 3,
  parameter int unsigned FIFO_CHUNK_SIZE      = 16,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned COUNT_WIDTH          = 16,
  parameter int unsigned ID_WIDTH             = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                                   M_AXIS_ACLK,
  input  logic                                                   M_AXIS_ARESETN,
  input  logic                                                   enable,
  input  logic [N_REQ-1:0]                                       req_valid,
  output logic [N_REQ-1:0]                                       req_ready,
  input  logic [N_REQ*FIFO_CHUNK_SIZE*C_M_AXIS_TDATA_WIDTH-1:0]  req_data,
  output logic                                                   fifo_write_strobe,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]                        fifo_in [0:FIFO_CHUNK_SIZE-1],
  input  logic                                                   fifo_full,
  output logic [ID_WIDTH-1:0]                                    grant_id,
  output logic                                                   busy,
  output logic [COUNT_WIDTH-1:0]                                 chunk_count
);

  localparam int unsigned W     = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned F     = FIFO_CHUNK_SIZE;
  localparam int unsigned PAD_N = 1 << ID_WIDTH;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [ID_WIDTH-1:0]    rr_ptr_q;
  logic [ID_WIDTH-1:0]    rr_ptr_d;
  logic [ID_WIDTH-1:0]    grant_id_q;
  logic [ID_WIDTH-1:0]    grant_id_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic [W-1:0]           hold_q    [0:F-1];
  logic [W-1:0]           hold_d    [0:F-1];
  logic [W-1:0]           win_chunk [0:F-1];

  logic [PAD_N-1:0]       valid_pad;
  logic [ID_WIDTH-1:0]    cand_id;
  logic [ID_WIDTH-1:0]    win_idx;
  logic                   win_found;
  logic                   hold_valid;
  logic                   drain;
  logic                   can_grant;
  logic                   handshake;

  // Hold state, drain and grant qualification
  assign hold_valid = (state_q == ST_HELD);
  assign drain      = hold_valid & ~fifo_full;
  // Reset gating keeps req_ready low while M_AXIS_ARESETN is asserted.
  assign can_grant  = M_AXIS_ARESETN & enable & (~hold_valid | drain);
  assign handshake  = can_grant & win_found;

  // Zero-padded request vector so any ID_WIDTH index is in range
  assign valid_pad = PAD_N'(req_valid);

  // Round-robin winner: first valid request at rr_ptr, rr_ptr+1, ... mod N_REQ.
  // Walking offsets from highest to lowest lets the smallest offset win last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_id   = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      cand_id = ID_WIDTH'((32'(rr_ptr_q) + 32'(k)) % 32'(N_REQ));
      if (valid_pad[cand_id]) begin
        win_found = 1'b1;
        win_idx   = cand_id;
      end
    end
  end

  // One-hot grant towards the producers
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_ready[i] = handshake & (win_idx == ID_WIDTH'(i));
    end
  end

  // Select the winning producer's chunk out of the flattened bus
  always_comb begin
    for (int w = 0; w < int'(F); w++) begin
      win_chunk[w] = '0;
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win_idx == ID_WIDTH'(i)) begin
        for (int w = 0; w < int'(F); w++) begin
          win_chunk[w] = req_data[((i * int'(F)) + w) * int'(W) +: W];
        end
      end
    end
  end

  // Next-state: a handshake always (re)loads the holding register, so a
  // drain and a grant in the same cycle keep one chunk per cycle flowing.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    count_d    = count_q;
    hold_d     = hold_q;

    if (drain) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (handshake) begin
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!handshake && drain) begin
          state_d = ST_EMPTY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (handshake) begin
      grant_id_d = win_idx;
      hold_d     = win_chunk;
      rr_ptr_d   = (win_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : (win_idx + ID_WIDTH'(1));
    end
  end

  // State and holding register
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      count_q    <= '0;
      for (int w = 0; w < int'(F); w++) begin
        hold_q[w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      count_q    <= count_d;
      for (int w = 0; w < int'(F); w++) begin
        hold_q[w] <= hold_d[w];
      end
    end
  end

  // Outputs
  assign fifo_write_strobe = drain;
  assign fifo_in           = hold_q;
  assign busy              = hold_valid;
  assign grant_id          = grant_id_q;
  assign chunk_count       = count_q;

endmodule
